// File: rtl/sbox_sub_pipe.sv
// Pipelined AES SubBytes / InvSubBytes unit with valid/ready streaming and a sideband tag.
// The table lookup sits in front of stage 1; later stages only register the result.
module sbox_sub_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int DATA_W = 8 * LANES;

    // Entry 0 occupies the most significant byte of each table.
    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        if (inv) begin
            return INV_SBOX_T[2047 - 8*int'(b) -: 8];
        end
        return SBOX_T[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [DATA_W-1:0] sub_word(input logic [DATA_W-1:0] w, input logic inv);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            r[8*l +: 8] = sub_byte(w[8*l +: 8], inv);
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_vld;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [TAG_W-1:0]  src_tag  [STAGES];
    logic [DATA_W-1:0] sub_word_c;

    assign sub_word_c = sub_word(in_data, in_inv);

    // A stage may load whenever it or any stage below it is empty, or the sink is taking a word.
    always_comb begin : adv_chain
        logic acc;
        acc = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = acc | ~vld_q[k];
            adv[k] = acc;
        end
    end

    always_comb begin
        src_vld     = '0;
        src_vld[0]  = in_valid;
        src_data[0] = sub_word_c;
        src_tag[0]  = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k]  = vld_q[k-1];
            src_data[k] = data_q[k-1];
            src_tag[k]  = tag_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k]  = vld_q[k];
            data_d[k] = data_q[k];
            tag_d[k]  = tag_q[k];
            if (adv[k]) begin
                vld_d[k]  = src_vld[k];
                data_d[k] = src_data[k];
                tag_d[k]  = src_tag[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign busy      = |vld_q;

endmodule
